// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg
// Definitions shared by the shared-bus fabric and its arbiter:
//   - bus_state_t : transaction FSM states (IDLE, REQ, WAIT, RESP)
//   - DEF_*       : default widths and timeout
//   - index_bits  : width of an index able to address n items (min 1)
package soc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } bus_state_t;

  localparam int DEF_NUM_MASTERS = 2;
  localparam int DEF_NUM_SLAVES  = 2;
  localparam int DEF_ADDR_WIDTH  = 6;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_TIMEOUT     = 15;

  function automatic int index_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soc_bus_fabric_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter over N requesters. The search starts one past the
// most recent grant and wraps, so a continuously requesting master can
// never be served twice in a row while another master is waiting.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   req[N-1:0]   : request vector
//   enable       : arbitration allowed this cycle (fabric idle)
//   grant[N-1:0] : one-hot grant (combinational, zero when disabled)
//   index        : encoded index of the granted requester
module rr_arbiter
  import soc_bus_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = index_bits(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic [IW-1:0] last_grant_reg;
  logic          found;
  int            cand;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    if (enable) begin
      for (int off = 1; off <= N; off++) begin
        cand = int'(last_grant_reg) + off;
        if (cand >= N) cand = cand - N;
        if (!found && req[IW'(cand)]) begin
          found               = 1'b1;
          grant[IW'(cand)]    = 1'b1;
          index               = IW'(cand);
        end
      end
    end
  end

  // Resetting to N-1 makes requester 0 the first winner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_reg <= IW'(N - 1);
    end else if (enable && |req) begin
      last_grant_reg <= index;
    end
  end

endmodule

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric
// Shared-bus interconnect: NUM_MASTERS requesters to NUM_SLAVES
// address-decoded targets, one transaction in flight at a time.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   m_req_valid    : per-master request, held until that master's m_data_valid
//   m_we/m_addr/m_wdata : packed per-master payload (master i in slice i)
//   m_data_valid   : one-hot completion pulse to the granted master
//   m_rdata/m_err  : shared response data / error, qualified by m_data_valid
//   s_req_valid    : one-cycle request pulse to the selected slave
//   s_we/s_addr/s_wdata : broadcast payload (s_addr is slave-local)
//   s_data_valid   : per-slave completion pulse
//   s_rdata        : packed per-slave read data
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter  int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter  int NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter  int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int TIMEOUT     = DEF_TIMEOUT,
  localparam int SEL_BITS    = index_bits(NUM_SLAVES),
  localparam int LOCAL_W     = ADDR_WIDTH - SEL_BITS
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_req_valid,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_data_valid,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              m_err,
  output logic [NUM_SLAVES-1:0]             s_req_valid,
  output logic                              s_we,
  output logic [LOCAL_W-1:0]                s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  input  logic [NUM_SLAVES-1:0]             s_data_valid,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_rdata
);

  localparam int MST_BITS = index_bits(NUM_MASTERS);
  localparam int CNT_W    = index_bits(TIMEOUT + 1);

  // Unpacked views of the packed buses.
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] rdata_arr [NUM_SLAVES];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mst
    assign addr_arr[gi]  = m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slv
    assign rdata_arr[gi] = s_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  bus_state_t            state_reg;
  logic [MST_BITS-1:0]   mst_reg;
  logic [SEL_BITS-1:0]   sel_reg;
  logic [CNT_W-1:0]      cnt_reg;

  logic [NUM_MASTERS-1:0] grant;
  logic [MST_BITS-1:0]    grant_idx;
  logic                   arb_enable;

  assign arb_enable = (state_reg == IDLE);

  rr_arbiter #(.N(NUM_MASTERS)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (m_req_valid),
    .enable (arb_enable),
    .grant  (grant),
    .index  (grant_idx)
  );

  // Payload of the master the arbiter is granting this cycle.
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [SEL_BITS-1:0]   pick_sel;
  logic                  pick_mapped;
  logic                  sel_dv;

  assign pick_addr   = addr_arr[grant_idx];
  assign pick_sel    = pick_addr[ADDR_WIDTH-1 -: SEL_BITS];
  // Only reachable with a non-power-of-two slave count.
  assign pick_mapped = ({1'b0, pick_sel} < (SEL_BITS+1)'(NUM_SLAVES));
  // Responses from slaves other than the selected one are never looked at.
  assign sel_dv      = s_data_valid[sel_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      mst_reg      <= '0;
      sel_reg      <= '0;
      cnt_reg      <= '0;
      m_data_valid <= '0;
      m_rdata      <= '0;
      m_err        <= 1'b0;
      s_req_valid  <= '0;
      s_we         <= 1'b0;
      s_addr       <= '0;
      s_wdata      <= '0;
    end else begin
      // Both strobes are single-cycle pulses.
      s_req_valid  <= '0;
      m_data_valid <= '0;
      unique case (state_reg)
        IDLE: begin
          if (|grant) begin
            mst_reg <= grant_idx;
            sel_reg <= pick_sel;
            cnt_reg <= '0;
            s_we    <= m_we[grant_idx];
            s_addr  <= pick_addr[LOCAL_W-1:0];
            s_wdata <= wdata_arr[grant_idx];
            if (pick_mapped) begin
              s_req_valid <= NUM_SLAVES'(1) << pick_sel;
              state_reg   <= REQ;
            end else begin
              m_data_valid <= grant;
              m_rdata      <= '0;
              m_err        <= 1'b1;
              state_reg    <= RESP;
            end
          end
        end
        REQ: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          // A response arriving in the final counted cycle still wins.
          if (sel_dv) begin
            m_data_valid <= NUM_MASTERS'(1) << mst_reg;
            m_rdata      <= s_we ? '0 : rdata_arr[sel_reg];
            m_err        <= 1'b0;
            state_reg    <= RESP;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            m_data_valid <= NUM_MASTERS'(1) << mst_reg;
            m_rdata      <= '0;
            m_err        <= 1'b1;
            state_reg    <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// tb_soc_bus_fabric
// Randomised and directed stimulus for soc_bus_fabric against a
// transaction-level reference model (round-robin order, address decode,
// expected latency and response). A second instance with three slaves
// covers unmapped decode.
module tb_soc_bus_fabric;

  localparam int NM  = 2;
  localparam int NS  = 2;
  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int TO  = 15;
  localparam int LW  = AW - 1;
  localparam int NS3 = 3;
  localparam int LW3 = AW - 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Main instance (2 masters, 2 slaves)
  logic [NM-1:0]    m_req_valid, m_we;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_data_valid;
  logic [DW-1:0]    m_rdata;
  logic             m_err;
  logic [NS-1:0]    s_req_valid;
  logic             s_we;
  logic [LW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [NS-1:0]    s_data_valid;
  logic [NS*DW-1:0] s_rdata;

  soc_bus_fabric #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW),
                   .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m_req_valid(m_req_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_data_valid(m_data_valid), .m_rdata(m_rdata), .m_err(m_err),
    .s_req_valid(s_req_valid), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_data_valid(s_data_valid), .s_rdata(s_rdata)
  );

  // Three-slave instance
  logic [NM-1:0]     u3_m_req_valid, u3_m_we;
  logic [NM*AW-1:0]  u3_m_addr;
  logic [NM*DW-1:0]  u3_m_wdata;
  logic [NM-1:0]     u3_m_data_valid;
  logic [DW-1:0]     u3_m_rdata;
  logic              u3_m_err;
  logic [NS3-1:0]    u3_s_req_valid;
  logic              u3_s_we;
  logic [LW3-1:0]    u3_s_addr;
  logic [DW-1:0]     u3_s_wdata;
  logic [NS3-1:0]    u3_s_data_valid;
  logic [NS3*DW-1:0] u3_s_rdata;

  soc_bus_fabric #(.NUM_MASTERS(NM), .NUM_SLAVES(NS3), .ADDR_WIDTH(AW),
                   .DATA_WIDTH(DW), .TIMEOUT(TO)) dut3 (
    .clk(clk), .reset(reset),
    .m_req_valid(u3_m_req_valid), .m_we(u3_m_we), .m_addr(u3_m_addr), .m_wdata(u3_m_wdata),
    .m_data_valid(u3_m_data_valid), .m_rdata(u3_m_rdata), .m_err(u3_m_err),
    .s_req_valid(u3_s_req_valid), .s_we(u3_s_we), .s_addr(u3_s_addr), .s_wdata(u3_s_wdata),
    .s_data_valid(u3_s_data_valid), .s_rdata(u3_s_rdata)
  );

  int n_checks;
  int n_errors;

  // Reference model state
  int              rr_last;
  logic            pay_we    [NM];
  logic [AW-1:0]   pay_addr  [NM];
  logic [DW-1:0]   pay_wdata [NM];
  bit              ovr_en;
  logic [DW-1:0]   ovr_word;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Content a slave returns for a local address.
  function automatic logic [DW-1:0] slave_word(input int s, input int a);
    return 32'hC0DE_0000 ^ (32'(s) << 20) ^ (32'(a) * 32'h0001_0203);
  endfunction

  task automatic drive_masters(input logic [NM-1:0] mask);
    m_req_valid = mask;
    for (int i = 0; i < NM; i++) begin
      m_we[i]              = pay_we[i];
      m_addr[i*AW +: AW]   = pay_addr[i];
      m_wdata[i*DW +: DW]  = pay_wdata[i];
    end
  endtask

  // One transaction: delay>0 means the addressed slave acks delay cycles
  // after its request pulse; delay==0 means it never answers.
  task automatic do_txn(input logic [NM-1:0] mask, input int delay, input bit stray, input string tag);
    int w, exp_sel, exp_local, exp_cycle, obs_sel;
    logic [LW-1:0] obs_addr;
    logic [DW-1:0] exp_rdata;
    bit got, extra_req;
    w = -1;
    for (int off = 1; off <= NM; off++) begin
      int cand;
      cand = (rr_last + off) % NM;
      if (w < 0 && mask[cand]) w = cand;
    end
    rr_last   = w;
    exp_sel   = int'(pay_addr[w][AW-1]);
    exp_local = int'(pay_addr[w][LW-1:0]);
    exp_cycle = (delay > 0) ? delay + 2 : TO + 2;
    if (delay == 0 || pay_we[w]) exp_rdata = '0;
    else exp_rdata = ovr_en ? ovr_word : slave_word(exp_sel, exp_local);
    drive_masters(mask);
    obs_sel = -1; obs_addr = '0; got = 0; extra_req = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk); #1;
      s_data_valid = '0;
      for (int s = 0; s < NS; s++) s_rdata[s*DW +: DW] = $urandom;
      if (c == 1) begin
        check({tag, " s_req_valid"}, s_req_valid, NS'(1) << exp_sel);
        check({tag, " s_addr"}, s_addr, exp_local);
        check({tag, " s_we"}, s_we, pay_we[w]);
        check({tag, " s_wdata"}, s_wdata, pay_wdata[w]);
        for (int s = 0; s < NS; s++) if (s_req_valid == NS'(1) << s) obs_sel = s;
        obs_addr = s_addr;
      end else if (s_req_valid != '0) begin
        extra_req = 1;
      end
      if (delay > 0 && c == 1 + delay && obs_sel >= 0) begin
        s_data_valid[obs_sel] = 1'b1;
        s_rdata[obs_sel*DW +: DW] = ovr_en ? ovr_word : slave_word(obs_sel, int'(obs_addr));
      end
      if (stray && c == 2) s_data_valid[1 - exp_sel] = 1'b1;
      if (m_data_valid != '0) begin
        got = 1;
        check({tag, " latency"}, c, exp_cycle);
        check({tag, " m_data_valid"}, m_data_valid, NM'(1) << w);
        check({tag, " m_rdata"}, m_rdata, exp_rdata);
        check({tag, " m_err"}, m_err, (delay == 0));
      end
    end
    if (!got) check({tag, " response seen"}, 0, 1);
    @(posedge clk); #1;
    s_data_valid = '0;
    check({tag, " pulse width"}, m_data_valid, 0);
    check({tag, " single s_req"}, extra_req | (s_req_valid != '0), 0);
    m_req_valid = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit bad;
    int d;
    n_checks = 0; n_errors = 0;
    reset = 1'b0; ovr_en = 0; ovr_word = '0; rr_last = NM - 1;
    m_req_valid = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    s_data_valid = '0; s_rdata = '0;
    u3_m_req_valid = '0; u3_m_we = '0; u3_m_addr = '0; u3_m_wdata = '0;
    u3_s_data_valid = '0; u3_s_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {m_data_valid, m_rdata, m_err, s_req_valid, s_we, s_addr, s_wdata}, 0);
    check("reset outputs u3", {u3_m_data_valid, u3_m_rdata, u3_m_err, u3_s_req_valid, u3_s_we, u3_s_addr, u3_s_wdata}, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Contention: both masters request back-to-back, grants alternate from 0.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NM; i++) begin
        pay_we[i] = 1'b0; pay_addr[i] = AW'($urandom); pay_wdata[i] = $urandom;
      end
      do_txn(2'b11, 1, 0, "contend");
    end

    // Single zero-wait read from slave 1.
    pay_we[0] = 1'b0; pay_addr[0] = 6'h25; pay_wdata[0] = '0;
    ovr_en = 1; ovr_word = 32'hDEADBEEF;
    do_txn(2'b01, 1, 0, "read");
    ovr_en = 0;

    // Write to slave 0, ack after three cycles.
    pay_we[0] = 1'b1; pay_addr[0] = 6'h0A; pay_wdata[0] = 32'h12345678;
    do_txn(2'b01, 3, 0, "write");

    // Timeout, then a late stray ack from the same slave.
    pay_we[0] = 1'b0; pay_addr[0] = 6'h33; pay_wdata[0] = '0;
    do_txn(2'b01, 0, 0, "timeout");
    bad = 0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      s_data_valid = (c == 1) ? 2'b10 : 2'b00;
      if (m_data_valid != '0 || s_req_valid != '0) bad = 1;
    end
    check("late ack ignored", bad, 0);

    // Randomised traffic.
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < NM; i++) begin
        pay_we[i] = 1'($urandom); pay_addr[i] = AW'($urandom); pay_wdata[i] = $urandom;
      end
      d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 14);
      do_txn(NM'($urandom_range(1, 3)), d, 1'($urandom), "random");
    end

    // Reset in the middle of WAIT.
    pay_we[0] = 1'b1; pay_addr[0] = 6'h1F; pay_wdata[0] = 32'hFFFF_FFFF;
    pay_we[1] = 1'b1; pay_addr[1] = 6'h1F; pay_wdata[1] = 32'hFFFF_FFFF;
    drive_masters(2'b11);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async reset outputs", {m_data_valid, m_rdata, m_err, s_req_valid, s_we, s_addr, s_wdata}, 0);
    m_req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    rr_last = NM - 1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (m_data_valid != '0 || s_req_valid != '0) bad = 1;
    end
    check("no response after reset", bad, 0);
    pay_we[0] = 1'b0; pay_addr[0] = 6'h07; pay_we[1] = 1'b0; pay_addr[1] = 6'h21;
    do_txn(2'b11, 2, 0, "post_reset");

    // Three-slave instance: unmapped access by master 1.
    u3_m_addr = {6'h30, 6'h25}; u3_m_we = '0; u3_m_req_valid = 2'b10;
    @(posedge clk); #1;
    check("unmapped m_data_valid", u3_m_data_valid, 2'b10);
    check("unmapped m_err", u3_m_err, 1);
    check("unmapped m_rdata", u3_m_rdata, 0);
    u3_m_req_valid = '0;
    bad = (u3_s_req_valid != '0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (u3_s_req_valid != '0 || u3_m_data_valid != '0) bad = 1;
    end
    check("unmapped no s_req", bad, 0);

    // Three-slave instance: mapped read from slave 2.
    u3_m_req_valid = 2'b01;
    @(posedge clk); #1;
    check("u3 s_req_valid", u3_s_req_valid, 3'b100);
    check("u3 s_addr", u3_s_addr, 4'h5);
    @(posedge clk); #1;
    u3_s_data_valid = 3'b100;
    u3_s_rdata = {32'hCAFEF00D, 32'h1111_1111, 32'h2222_2222};
    @(posedge clk); #1;
    u3_s_data_valid = '0;
    check("u3 m_data_valid", u3_m_data_valid, 2'b01);
    check("u3 m_rdata", u3_m_rdata, 32'hCAFEF00D);
    check("u3 m_err", u3_m_err, 0);
    u3_m_req_valid = '0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/soc_bus_fabric.md
# soc_bus_fabric

Parametrised shared-bus interconnect that replaces the point-to-point core-to-memory wiring at SoC top. Connects NUM_MASTERS requesters (cores, DMA) to NUM_SLAVES address-decoded targets (memory banks, peripherals) using the existing valid/we/addr/data protocol with separated read and write data. Provides round-robin arbitration, one transaction in flight, response routing back to the requester, and a timeout error for unresponsive slaves.

## Interface
- NUM_MASTERS, default 2: requester count, range 2..8.
- NUM_SLAVES, default 2: target count, range 2..8; need not be a power of two.
- ADDR_WIDTH, default 6: byte/word address width, matching the $clog2(MEM_DEPTH=64) memory address.
- DATA_WIDTH, default 32: data width.
- TIMEOUT, default 15: wait cycles before an error response; must be ≥1.
- SEL_BITS (derived): $clog2(NUM_SLAVES); the top SEL_BITS address bits select the slave.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- m_req_valid  in  NUM_MASTERS  per-master request; held high until that master's m_data_valid.
- m_we  in  NUM_MASTERS  per-master write enable.
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i occupies slice i.
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  packed write data.
- m_data_valid  out  NUM_MASTERS  one-cycle completion pulse for reads and writes.
- m_rdata  out  DATA_WIDTH  read data, shared by all masters; qualified by m_data_valid.
- m_err  out  1  error flag, qualified by m_data_valid.
- s_req_valid  out  NUM_SLAVES  one-cycle request pulse to the selected slave.
- s_we  out  1  write enable, broadcast to all slaves.
- s_addr  out  ADDR_WIDTH-SEL_BITS  slave-local address, broadcast.
- s_wdata  out  DATA_WIDTH  write data, broadcast.
- s_data_valid  in  NUM_SLAVES  per-slave completion pulse.
- s_rdata  in  NUM_SLAVES*DATA_WIDTH  packed read data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - If any m_req_valid is high, the round-robin arbiter grants one master.
  - On the grant, register the granted master's we, addr and wdata, plus the master index.
  - Decode sel = addr[ADDR_WIDTH-1 -: SEL_BITS].
  - If sel < NUM_SLAVES, go to REQ. Otherwise (unmapped), go to RESP with err=1 and rdata=0.
- **REQ**: s_req_valid[sel]=1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - Accept only s_data_valid[sel]. On it, capture s_rdata slice sel (zero for writes), err=0, go to RESP.
  - The timeout counter counts WAIT cycles. When it reaches TIMEOUT, set err=1 and rdata=0, go to RESP.
  - s_data_valid from any non-selected slave is ignored in every state.
- **RESP**: m_data_valid[granted]=1 for one cycle with m_rdata/m_err, then go to IDLE.
- **Round-robin arbiter**
  - Priority search starts at last_grant+1 and wraps modulo NUM_MASTERS.
  - last_grant updates only on a grant.
  - Reset value of last_grant is NUM_MASTERS-1, so master 0 wins first.
- A master's request changing while it is not granted has no effect. Once granted, its payload is frozen in registers.
- **Reset** (asynchronous, any state, including mid-transaction): return to IDLE and clear every output. Any in-flight transaction is dropped without a response.

## Timing
- All outputs are registered. Reset values: m_data_valid=0, m_rdata=0, m_err=0, s_req_valid=0, s_we=0, s_addr=0, s_wdata=0. Counter=0, state=IDLE.
- Cycle sequence, with the request first sampled at edge 0:
  - s_req_valid is high during cycle 1.
  - The slave responds with s_data_valid during cycle k≥2.
  - m_data_valid is high during cycle k+1.
- Zero-wait slave (responds in the cycle after s_req_valid): 3-cycle request-to-response latency.
- Unmapped address: m_data_valid during cycle 1.
- Timeout: m_data_valid with err=1 exactly TIMEOUT+2 cycles after the grant edge.
- Masters deassert m_req_valid at the edge ending RESP. A request still high in IDLE is treated as a new transaction.
- Back-to-back throughput: one transaction per (latency+1) cycles.

## Structure
- Shared package soc_bus_pkg holds:
  - the FSM state enum (IDLE/REQ/WAIT/RESP);
  - the default width constants;
  - a localparam helper for SEL_BITS.
- One sub-module: rr_arbiter, parameterised by N. Inputs are req[N-1:0] and an enable; outputs are a one-hot grant and an encoded index. It holds the last_grant register.
- Slice selection, address decode and the timeout counter live in soc_bus_fabric.

## Test plan
- Single read, NUM_MASTERS=2, NUM_SLAVES=2, zero-wait slave 1 returning 0xDEADBEEF. Master 0 reads addr 0x25. Required response:
  - s_req_valid=2'b10 and s_addr=0x05 in cycle 1;
  - m_data_valid=2'b01 with m_rdata=0xDEADBEEF and m_err=0 in cycle 3.
- Contention: both masters request continuously from reset. Grants alternate 0,1,0,1 over four transactions, with no master served twice in a row.
- Timeout, TIMEOUT=15: the slave never responds. m_err=1 and m_rdata=0 with m_data_valid 17 cycles after the grant edge. A later stray s_data_valid from that slave is ignored.
- Unmapped address, NUM_SLAVES=3: master 1 accesses addr 0x30 (sel=3). The response is err=1 in cycle 1 and no s_req_valid is ever asserted.
- Write: master 0 writes 0x12345678 to 0x0A. In cycle 1: s_we=1, s_wdata=0x12345678, s_req_valid=2'b01. m_data_valid follows the slave ack by one cycle.
- Reset mid-WAIT: drive reset=0 asynchronously. All outputs are 0 immediately and no m_data_valid follows. After release, master 0 wins first.
